// File: rtl/fetch_unit.sv
// Two-wide fetch stage: one outstanding 64-bit imem read, responses packed into IF_IB_PACKET pairs.
// Optional macro FETCH_PERF_EN adds saturating bundle/drop counters (perf_bundles, perf_drops).

package fetch_pkg;
    localparam int XLEN = 32;

    typedef struct packed {
        logic            valid;
        logic [31:0]     inst;
        logic [XLEN-1:0] PC;
        logic [XLEN-1:0] NPC;
    } IF_IB_PACKET;
endpackage

module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   squash,
    input  logic [XLEN-1:0]        squash_pc,
    input  logic                   ib_stall,
    output logic                   proc2Imem_req,
    output logic [XLEN-1:0]        proc2Imem_addr,
    input  logic                   Imem2proc_ack,
    input  logic                   Imem2proc_valid,
    input  logic [63:0]            Imem2proc_data,
`ifdef FETCH_PERF_EN
    output logic [31:0]            perf_bundles,
    output logic [15:0]            perf_drops,
`endif
    output IF_IB_PACKET [0:1]      if_ib_packet
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    IF_IB_PACKET [0:1] pkt_q, pkt_d;
    logic [XLEN-1:0]   base;
    logic              emit;

    assign base           = {pc_q[XLEN-1:3], 3'b000};
    assign proc2Imem_req  = (state_q == REQ);
    assign proc2Imem_addr = base;
    assign if_ib_packet   = pkt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pkt_q   <= pkt_d;
        end
    end

    // Squash wins over everything; an acked-but-undelivered read must be drained in DROP.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        emit    = 1'b0;
        if (squash) begin
            pc_d = squash_pc & ~XLEN'(3);
            case (state_q)
                IDLE:    state_d = IDLE;
                REQ:     state_d = Imem2proc_ack ? DROP : IDLE;
                WAIT,
                DROP:    state_d = Imem2proc_valid ? IDLE : DROP;
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE:    if (!ib_stall) state_d = REQ;
                REQ:     if (Imem2proc_ack) state_d = WAIT;
                WAIT: begin
                    if (Imem2proc_valid) begin
                        emit    = 1'b1;
                        pc_d    = base + XLEN'(8);
                        state_d = ib_stall ? IDLE : REQ;
                    end
                end
                DROP:    if (Imem2proc_valid) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // A fetch PC in the upper word of the line yields a single-slot bundle.
    always_comb begin
        pkt_d = '0;
        if (emit) begin
            if (!pc_q[2]) begin
                pkt_d[0].valid = 1'b1;
                pkt_d[0].inst  = Imem2proc_data[31:0];
                pkt_d[0].PC    = base;
                pkt_d[0].NPC   = base + XLEN'(4);
                pkt_d[1].valid = 1'b1;
                pkt_d[1].inst  = Imem2proc_data[63:32];
                pkt_d[1].PC    = base + XLEN'(4);
                pkt_d[1].NPC   = base + XLEN'(8);
            end else begin
                pkt_d[0].valid = 1'b1;
                pkt_d[0].inst  = Imem2proc_data[63:32];
                pkt_d[0].PC    = base + XLEN'(4);
                pkt_d[0].NPC   = base + XLEN'(8);
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] bundles_q;
    logic [15:0] drops_q;
    logic        dropEvt;

    assign dropEvt = Imem2proc_valid &&
                     ((state_q == DROP) || (state_q == WAIT && squash));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bundles_q <= '0;
            drops_q   <= '0;
        end else begin
            if (emit && bundles_q != '1) bundles_q <= bundles_q + 32'd1;
            if (dropEvt && drops_q != '1) drops_q <= drops_q + 16'd1;
        end
    end

    assign perf_bundles = bundles_q;
    assign perf_drops   = drops_q;
`else
    // Counters are compiled out; the datapath above is unchanged.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural imem acks in one cycle and returns data two cycles later.
// Expected bundles are queued by each scenario and matched by a monitor as the DUT emits them.

module tb_fetch_unit;
    import fetch_pkg::*;

    typedef IF_IB_PACKET [0:1] bundle_t;

    localparam int MEM_LAT = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        squash = 1'b0;
    logic [31:0] squash_pc = 32'h0;
    logic        ib_stall = 1'b0;
    logic        Imem2proc_ack = 1'b0;
    logic        Imem2proc_valid = 1'b0;
    logic [63:0] Imem2proc_data = 64'h0;
    logic        proc2Imem_req;
    logic [31:0] proc2Imem_addr;
    bundle_t     if_ib_packet;
`ifdef FETCH_PERF_EN
    logic [31:0] perfBundles;
    logic [15:0] perfDrops;
`endif

    int          checks = 0;
    int          failures = 0;
    bundle_t     expQ[$];
    bundle_t     monExp;
    int          acksLeft = 0;
    int          respCnt = 0;
    bit          ackPending = 1'b0;
    logic [31:0] memAddr = 32'h0;

    fetch_unit dut (
        .clock           (clock),
        .reset           (reset),
        .squash          (squash),
        .squash_pc       (squash_pc),
        .ib_stall        (ib_stall),
        .proc2Imem_req   (proc2Imem_req),
        .proc2Imem_addr  (proc2Imem_addr),
        .Imem2proc_ack   (Imem2proc_ack),
        .Imem2proc_valid (Imem2proc_valid),
        .Imem2proc_data  (Imem2proc_data),
`ifdef FETCH_PERF_EN
        .perf_bundles    (perfBundles),
        .perf_drops      (perfDrops),
`endif
        .if_ib_packet    (if_ib_packet)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] memData(input logic [31:0] a);
        if (a == 32'h0) return 64'h0000_0013_0010_0093;
        return {a + 32'h1000_0004, a + 32'h1000_0000};
    endfunction

    function automatic bundle_t expBundle(input logic [31:0] pc, input logic [63:0] d);
        bundle_t     b;
        logic [31:0] baseAddr;
        b        = '0;
        baseAddr = {pc[31:3], 3'b000};
        if (!pc[2]) begin
            b[0].valid = 1'b1; b[0].inst = d[31:0];  b[0].PC = baseAddr;         b[0].NPC = baseAddr + 32'd4;
            b[1].valid = 1'b1; b[1].inst = d[63:32]; b[1].PC = baseAddr + 32'd4; b[1].NPC = baseAddr + 32'd8;
        end else begin
            b[0].valid = 1'b1; b[0].inst = d[63:32]; b[0].PC = baseAddr + 32'd4; b[0].NPC = baseAddr + 32'd8;
        end
        return b;
    endfunction

    // Imem model: one outstanding read, acks a held request if the scenario allows, data MEM_LAT later.
    always @(negedge clock) begin
        Imem2proc_valid = 1'b0;
        Imem2proc_ack   = 1'b0;
        if (!reset) begin
            respCnt    = 0;
            ackPending = 1'b0;
        end else begin
            if (ackPending) begin
                ackPending = 1'b0;
                respCnt    = MEM_LAT;
            end
            if (respCnt > 0) begin
                respCnt--;
                if (respCnt == 0) begin
                    Imem2proc_valid = 1'b1;
                    Imem2proc_data  = memData(memAddr);
                end
            end
            if (proc2Imem_req && acksLeft > 0 && respCnt == 0 && !ackPending) begin
                Imem2proc_ack = 1'b1;
                acksLeft--;
                ackPending = 1'b1;
                memAddr    = proc2Imem_addr;
            end
        end
    end

    // Every valid bundle must match the oldest queued expectation.
    always @(negedge clock) begin
        if (if_ib_packet[0].valid === 1'b1 || if_ib_packet[1].valid === 1'b1) begin
            checks++;
            if (expQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL bundle_unexpected got=%h want=none", if_ib_packet);
            end else begin
                monExp = expQ.pop_front();
                if (if_ib_packet !== monExp) begin
                    failures++;
                    $display("[TB] FAIL bundle got=%h want=%h", if_ib_packet, monExp);
                end
            end
        end
    end

    task automatic stepCycle();
        @(negedge clock);
        #1;
    endtask

    task automatic test_reset();
        stepCycle();
        stepCycle();
        checks++;
        if (proc2Imem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_req got=%b want=0", proc2Imem_req); end
        checks++;
        if (proc2Imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_addr got=%h want=0", proc2Imem_addr); end
        checks++;
        if (if_ib_packet !== '0) begin failures++; $display("[TB] FAIL reset_pkt got=%h want=0", if_ib_packet); end
`ifdef FETCH_PERF_EN
        checks++;
        if (perfBundles !== 32'd0 || perfDrops !== 16'd0) begin failures++; $display("[TB] FAIL reset_perf got=%0d/%0d want=0/0", perfBundles, perfDrops); end
`endif
    endtask

    task automatic test_basic();
        bundle_t b;
        b = '0;
        b[0].valid = 1'b1; b[0].inst = 32'h0010_0093; b[0].PC = 32'h0; b[0].NPC = 32'h4;
        b[1].valid = 1'b1; b[1].inst = 32'h0000_0013; b[1].PC = 32'h4; b[1].NPC = 32'h8;
        expQ.push_back(b);
        acksLeft = 1;
        reset    = 1'b1;
        stepCycle();
        checks++;
        if (proc2Imem_req !== 1'b1 || proc2Imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL basic_first_req got=%b/%h want=1/00000000", proc2Imem_req, proc2Imem_addr); end
        for (int n = 0; n < 30 && expQ.size() != 0; n++) stepCycle();
        checks++;
        if (expQ.size() != 0) begin failures++; $display("[TB] FAIL basic_drain got=%0d want=0 pending", expQ.size()); expQ.delete(); end
        checks++;
        if (proc2Imem_req !== 1'b1 || proc2Imem_addr !== 32'h8) begin failures++; $display("[TB] FAIL basic_next_req got=%b/%h want=1/00000008", proc2Imem_req, proc2Imem_addr); end
    endtask

    task automatic test_squash_wait();
        acksLeft = 1;
        stepCycle();
        stepCycle();
        squash    = 1'b1;
        squash_pc = 32'h0000_0107;
        stepCycle();
        squash = 1'b0;
        checks++;
        if (proc2Imem_req !== 1'b0) begin failures++; $display("[TB] FAIL sqw_drop_req got=%b want=0", proc2Imem_req); end
        stepCycle();
        checks++;
        if (proc2Imem_req !== 1'b0) begin failures++; $display("[TB] FAIL sqw_idle_req got=%b want=0", proc2Imem_req); end
        expQ.push_back(expBundle(32'h104, memData(32'h100)));
        acksLeft = 1;
        stepCycle();
        checks++;
        if (proc2Imem_req !== 1'b1 || proc2Imem_addr !== 32'h100) begin failures++; $display("[TB] FAIL sqw_redirect got=%b/%h want=1/00000100", proc2Imem_req, proc2Imem_addr); end
        for (int n = 0; n < 30 && expQ.size() != 0; n++) stepCycle();
        checks++;
        if (expQ.size() != 0) begin failures++; $display("[TB] FAIL sqw_drain got=%0d want=0 pending", expQ.size()); expQ.delete(); end
        checks++;
        if (proc2Imem_req !== 1'b1 || proc2Imem_addr !== 32'h108) begin failures++; $display("[TB] FAIL sqw_next got=%b/%h want=1/00000108", proc2Imem_req, proc2Imem_addr); end
    endtask

    task automatic test_squash_valid();
        acksLeft = 1;
        stepCycle();
        stepCycle();
        stepCycle();
        squash    = 1'b1;
        squash_pc = 32'h0000_0200;
        stepCycle();
        squash = 1'b0;
        checks++;
        if (proc2Imem_req !== 1'b0) begin failures++; $display("[TB] FAIL sqv_idle got=%b want=0", proc2Imem_req); end
`ifdef FETCH_PERF_EN
        checks++;
        if (perfDrops !== 16'd2) begin failures++; $display("[TB] FAIL sqv_perf_drops got=%0d want=2", perfDrops); end
`endif
        stepCycle();
        checks++;
        if (proc2Imem_req !== 1'b1 || proc2Imem_addr !== 32'h200) begin failures++; $display("[TB] FAIL sqv_redirect got=%b/%h want=1/00000200", proc2Imem_req, proc2Imem_addr); end
    endtask

    task automatic test_ib_stall_idle();
        ib_stall  = 1'b1;
        squash    = 1'b1;
        squash_pc = 32'h0000_0300;
        stepCycle();
        squash = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (proc2Imem_req !== 1'b0) begin failures++; $display("[TB] FAIL stall_idle_req cycle=%0d got=%b want=0", i, proc2Imem_req); end
            stepCycle();
        end
        ib_stall = 1'b0;
        stepCycle();
        checks++;
        if (proc2Imem_req !== 1'b1 || proc2Imem_addr !== 32'h300) begin failures++; $display("[TB] FAIL stall_release got=%b/%h want=1/00000300", proc2Imem_req, proc2Imem_addr); end
    endtask

    task automatic test_ib_stall_wait();
        expQ.push_back(expBundle(32'h300, memData(32'h300)));
        acksLeft = 1;
        stepCycle();
        stepCycle();
        ib_stall = 1'b1;
        stepCycle();
        stepCycle();
        checks++;
        if (expQ.size() != 0) begin failures++; $display("[TB] FAIL stall_wait_bundle got=%0d want=0 pending", expQ.size()); expQ.delete(); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (proc2Imem_req !== 1'b0) begin failures++; $display("[TB] FAIL stall_wait_req cycle=%0d got=%b want=0", i, proc2Imem_req); end
            stepCycle();
        end
        ib_stall = 1'b0;
        stepCycle();
        checks++;
        if (proc2Imem_req !== 1'b1 || proc2Imem_addr !== 32'h308) begin failures++; $display("[TB] FAIL stall_wait_resume got=%b/%h want=1/00000308", proc2Imem_req, proc2Imem_addr); end
    endtask

    task automatic test_reset_mid_wait();
        acksLeft = 1;
        stepCycle();
        stepCycle();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (proc2Imem_req !== 1'b0 || if_ib_packet !== '0) begin failures++; $display("[TB] FAIL rst_async got=%b/%h want=0/0", proc2Imem_req, if_ib_packet); end
        checks++;
        if (proc2Imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL rst_addr got=%h want=0", proc2Imem_addr); end
`ifdef FETCH_PERF_EN
        checks++;
        if (perfBundles !== 32'd0 || perfDrops !== 16'd0) begin failures++; $display("[TB] FAIL rst_perf got=%0d/%0d want=0/0", perfBundles, perfDrops); end
`endif
        stepCycle();
        stepCycle();
        acksLeft = 0;
        reset    = 1'b1;
        stepCycle();
        checks++;
        if (proc2Imem_req !== 1'b1 || proc2Imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL rst_release got=%b/%h want=1/00000000", proc2Imem_req, proc2Imem_addr); end
    endtask

    task automatic test_wrap();
        squash    = 1'b1;
        squash_pc = 32'hFFFF_FFFE;
        stepCycle();
        squash = 1'b0;
        stepCycle();
        checks++;
        if (proc2Imem_req !== 1'b1 || proc2Imem_addr !== 32'hFFFF_FFF8) begin failures++; $display("[TB] FAIL wrap_addr got=%b/%h want=1/fffffff8", proc2Imem_req, proc2Imem_addr); end
        expQ.push_back(expBundle(32'hFFFF_FFFC, memData(32'hFFFF_FFF8)));
        acksLeft = 1;
        for (int n = 0; n < 30 && expQ.size() != 0; n++) stepCycle();
        checks++;
        if (expQ.size() != 0) begin failures++; $display("[TB] FAIL wrap_drain got=%0d want=0 pending", expQ.size()); expQ.delete(); end
        checks++;
        if (proc2Imem_req !== 1'b1 || proc2Imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL wrap_next got=%b/%h want=1/00000000", proc2Imem_req, proc2Imem_addr); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) expQ.push_back(expBundle(32'(i * 8), memData(32'(i * 8))));
        acksLeft = 3;
        for (int n = 0; n < 40 && expQ.size() != 0; n++) stepCycle();
        checks++;
        if (expQ.size() != 0) begin failures++; $display("[TB] FAIL b2b_drain got=%0d want=0 pending", expQ.size()); expQ.delete(); end
        checks++;
        if (proc2Imem_req !== 1'b1 || proc2Imem_addr !== 32'h18) begin failures++; $display("[TB] FAIL b2b_next got=%b/%h want=1/00000018", proc2Imem_req, proc2Imem_addr); end
`ifdef FETCH_PERF_EN
        checks++;
        if (perfBundles !== 32'd4) begin failures++; $display("[TB] FAIL b2b_perf_bundles got=%0d want=4", perfBundles); end
`endif
    endtask

    initial begin
        $display("[TB] fetch_unit bench start");
        test_reset();
        test_basic();
        test_squash_wait();
        test_squash_valid();
        test_ib_stall_idle();
        test_ib_stall_wait();
        test_reset_mid_wait();
        test_wrap();
        test_back_to_back();
        stepCycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Two-wide instruction fetch stage sitting directly upstream of the instruction buffer.
- Holds the fetch PC and issues 64-bit aligned instruction-memory reads, one outstanding at a time.
- Returns each response as an IF_IB_PACKET pair into the buffer.
- On squash, redirects to a new PC and discards any in-flight response.

Parameters:
- RESET_PC, 32'h0000_0000: fetch PC after reset.
- XLEN, 32: PC/address width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset; low clears all state immediately.
- squash  in  1  redirect request from the back end.
- squash_pc  in  XLEN  redirect target; bit[1:0] are ignored.
- ib_stall  in  1  from the instruction buffer; high when at most one bundle slot is free.
- proc2Imem_req  out  1  read request, held until acknowledged.
- proc2Imem_addr  out  XLEN  {fetch_pc[XLEN-1:3],3'b0}.
- Imem2proc_ack  in  1  memory accepts the request this cycle.
- Imem2proc_valid  in  1  read data valid, one cycle.
- Imem2proc_data  in  64  two instructions: [31:0] is the lower address, [63:32] the upper.
- if_ib_packet  out  IF_IB_PACKET[0:1]  bundle to the buffer; slot0.valid is the write strobe.

Behaviour:
- Reset (asynchronous, reset==0):
  - state=IDLE, fetch_pc=RESET_PC, proc2Imem_req=0.
  - if_ib_packet all fields 0.
  - Memory is reset alongside, so no stale response can follow.
- States:
  - IDLE: if !ib_stall && !squash, go to REQ next cycle.
  - REQ: proc2Imem_req=1 and address stable. On Imem2proc_ack, go to WAIT.
  - WAIT: on Imem2proc_valid, emit the bundle and set fetch_pc += 8 (aligned base + 8). Then go to REQ if !ib_stall, else IDLE.
  - DROP: on Imem2proc_valid, discard the data and go to IDLE.
- Squash (any state, highest priority):
  - fetch_pc <= {squash_pc[XLEN-1:2],2'b00}.
  - IDLE or REQ without ack in the same cycle: go to IDLE; the request is withdrawn.
  - REQ with ack in the same cycle, WAIT, or DROP: go to DROP.
  - WAIT with Imem2proc_valid in the same cycle: the response is discarded, no bundle is emitted, go to IDLE.
- Bundle formation (registered; if_ib_packet valid for exactly one cycle after a response, otherwise both .valid=0):
  - fetch_pc[2]==0:
    - slot0 = {valid 1, inst data[31:0], PC base, NPC base+4}.
    - slot1 = {valid 1, inst data[63:32], PC base+4, NPC base+8}.
  - fetch_pc[2]==1:
    - slot0 = {valid 1, inst data[63:32], PC base+4, NPC base+8}.
    - slot1 all 0.
  - slot0.valid is never 0 while slot1.valid is 1.
- Throughput and latency:
  - Best case is one bundle per 2 cycles plus memory latency.
  - Request to bundle output = ack cycle + memory latency + 1 register.
- ib_stall:
  - Sampled only at IDLE to REQ and WAIT to REQ decisions.
  - An outstanding response is always delivered. The buffer guarantees one free slot while ib_stall is high.
- PC arithmetic: modulo 2^XLEN; wrap from 32'hFFFF_FFF8 to 0 is legal.

Optional Feature:
- FETCH_PERF_EN defined: adds two saturating counters, cleared by reset and holding at max.
  - perf_bundles out 32: increments per emitted bundle.
  - perf_drops out 16: increments per discarded response (DROP exit, or squash coincident with valid in WAIT).
- Undefined: ports and counters are absent; functional behaviour is identical.

Test Plan:
- Reset release, memory acks in 1 cycle, data 64'h0000_0013_0010_0093 after 2 cycles → addr 0, then addr 8. Bundle: slot0 PC 0 inst 32'h00100093, slot1 PC 4 inst 32'h00000013, NPC 4/8.
- Squash to 32'h0000_0104 while in WAIT → response discarded (no valid bundle), DROP then IDLE. Next addr 32'h100; bundle has slot0 PC 32'h104 inst data[63:32], slot1.valid=0.
- Squash coincident with Imem2proc_valid in WAIT → no bundle, fetch_pc = squash_pc, state IDLE; with FETCH_PERF_EN, perf_drops = 1.
- ib_stall held high from IDLE for 10 cycles → proc2Imem_req stays 0. Deassert → req rises the next cycle with the unchanged address.
- ib_stall rises while in WAIT → bundle still emitted, then IDLE, and no new request until ib_stall falls.
- reset driven low mid-WAIT, off the clock edge → req and packets go to 0 immediately. After release, addr = RESET_PC.
